// File: rtl/hazard_sb.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load-use/branch stalls,
// a scoreboard for one non-pipelined multi-cycle unit, and a saturating stall counter.
module hazard_sb #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              branchD_i,
  input  logic              mcD_i,
  input  logic [REG_AW-1:0] rsD_i,
  input  logic [REG_AW-1:0] rtD_i,
  input  logic [REG_AW-1:0] rsE_i,
  input  logic [REG_AW-1:0] rtE_i,
  input  logic [REG_AW-1:0] writeregE_i,
  input  logic [REG_AW-1:0] writeregM_i,
  input  logic [REG_AW-1:0] writeregW_i,
  input  logic              regwriteE_i,
  input  logic              regwriteM_i,
  input  logic              regwriteW_i,
  input  logic              memtoregE_i,
  input  logic              memtoregM_i,
  input  logic              mcstartE_i,
  output logic              stallF_o,
  output logic              stallD_o,
  output logic              flushE_o,
  output logic              forwardAD_o,
  output logic              forwardBD_o,
  output logic [1:0]        forwardAE_o,
  output logic [1:0]        forwardBE_o,
  output logic              mcbusy_o,
  output logic              mcdone_o,
  output logic [REG_AW-1:0] mcdest_o,
  output logic [CNT_W-1:0]  stallcnt_o
);

  localparam int CW = $clog2(MC_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mcState_t;

  mcState_t          state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [REG_AW-1:0] mcdest_q, mcdest_d;
  logic [CNT_W-1:0]  stallcnt_q, stallcnt_d;

  logic mcdone, mcActive, lwstall, brstall, mcstall, stall;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcdest_q   <= '0;
      stallcnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcdest_q   <= mcdest_d;
      stallcnt_q <= stallcnt_d;
    end
  end

  // A start while BUSY is ignored; the counter hits 0 in the write-back cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcdest_d = mcdest_q;
    mcdone   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mcstartE_i) begin
          state_d  = BUSY;
          cnt_d    = CNT_LOAD;
          mcdest_d = writeregE_i;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          mcdone  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    forwardAE_o = 2'b00;
    if (regwriteM_i && hit(rsE_i, writeregM_i))      forwardAE_o = 2'b10;
    else if (regwriteW_i && hit(rsE_i, writeregW_i)) forwardAE_o = 2'b01;
    forwardBE_o = 2'b00;
    if (regwriteM_i && hit(rtE_i, writeregM_i))      forwardBE_o = 2'b10;
    else if (regwriteW_i && hit(rtE_i, writeregW_i)) forwardBE_o = 2'b01;
  end

  // The mcdone cycle no longer blocks: the register file writes before decode reads.
  assign mcActive = (state_q == BUSY) && !mcdone;

  assign lwstall = memtoregE_i && (hit(rsD_i, rtE_i) || hit(rtD_i, rtE_i));
  assign brstall = branchD_i &&
                   ((regwriteE_i && (hit(rsD_i, writeregE_i) || hit(rtD_i, writeregE_i))) ||
                    (memtoregM_i && (hit(rsD_i, writeregM_i) || hit(rtD_i, writeregM_i))));
  assign mcstall = (mcstartE_i && (hit(rsD_i, writeregE_i) || hit(rtD_i, writeregE_i))) ||
                   (mcActive && (hit(rsD_i, mcdest_q) || hit(rtD_i, mcdest_q))) ||
                   (mcD_i && (mcstartE_i || mcActive));
  assign stall   = lwstall || brstall || mcstall;

  always_comb begin
    stallcnt_d = stallcnt_q;
    if (stall && (stallcnt_q != '1)) stallcnt_d = stallcnt_q + CNT_W'(1);
  end

  assign stallF_o    = stall;
  assign stallD_o    = stall;
  assign flushE_o    = stall;
  assign forwardAD_o = regwriteM_i && hit(rsD_i, writeregM_i);
  assign forwardBD_o = regwriteM_i && hit(rtD_i, writeregM_i);
  assign mcbusy_o    = (state_q == BUSY);
  assign mcdone_o    = mcdone;
  assign mcdest_o    = mcdest_q;
  assign stallcnt_o  = stallcnt_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: directed scenarios plus random traffic, every cycle checked
// against an elapsed-cycle reference model of the hazard rules.
module tb_hazard_sb;
  localparam int REG_AW = 5;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, branchD, mcD, regwriteE, regwriteM, regwriteW;
  logic memtoregE, memtoregM, mcstartE;
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic stallF, stallD, flushE, forwardAD, forwardBD, mcbusy, mcdone;
  logic [1:0] forwardAE, forwardBE;
  logic [REG_AW-1:0] mcdest;
  logic [CNT_W-1:0] stallcnt;

  hazard_sb #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset), .branchD_i(branchD), .mcD_i(mcD),
    .rsD_i(rsD), .rtD_i(rtD), .rsE_i(rsE), .rtE_i(rtE),
    .writeregE_i(writeregE), .writeregM_i(writeregM), .writeregW_i(writeregW),
    .regwriteE_i(regwriteE), .regwriteM_i(regwriteM), .regwriteW_i(regwriteW),
    .memtoregE_i(memtoregE), .memtoregM_i(memtoregM), .mcstartE_i(mcstartE),
    .stallF_o(stallF), .stallD_o(stallD), .flushE_o(flushE),
    .forwardAD_o(forwardAD), .forwardBD_o(forwardBD),
    .forwardAE_o(forwardAE), .forwardBE_o(forwardBE),
    .mcbusy_o(mcbusy), .mcdone_o(mcdone), .mcdest_o(mcdest), .stallcnt_o(stallcnt)
  );

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: the op in flight is tracked by the cycle number it started in.
  int cyc = 0;
  bit mcInFlight = 1'b0;
  int mcStart = 0;
  logic [REG_AW-1:0] mcDestRef = '0;
  int stallTotal = 0;

  function automatic bit hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && (a != 0);
  endfunction

  function automatic logic [1:0] fwdE(input logic [REG_AW-1:0] r);
    if (regwriteM && hit(r, writeregM)) return 2'b10;
    if (regwriteW && hit(r, writeregW)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
  endtask

  task automatic clearInputs();
    reset = 0; branchD = 0; mcD = 0; regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; mcstartE = 0;
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
  endtask

  // Called just after a falling edge with the inputs already driven; runs one cycle.
  task automatic applyStimulus();
    bit expDone, mcActive, lw, br, mcRaw, mcStruct, expStall;
    int expCnt;
    #1;
    expDone  = mcInFlight && ((cyc - mcStart) == MC_LAT);
    mcActive = mcInFlight && !expDone;
    lw = memtoregE && (hit(rsD, rtE) || hit(rtD, rtE));
    br = branchD && ((regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE))) ||
                     (memtoregM && (hit(rsD, writeregM) || hit(rtD, writeregM))));
    mcRaw = (mcstartE && (hit(rsD, writeregE) || hit(rtD, writeregE))) ||
            (mcActive && (hit(rsD, mcDestRef) || hit(rtD, mcDestRef)));
    mcStruct = mcD && (mcstartE || mcActive);
    expStall = lw || br || mcRaw || mcStruct;
    expCnt = (stallTotal > CNT_MAX) ? CNT_MAX : stallTotal;

    checkOutput("stallF", 32'(stallF), 32'(expStall));
    checkOutput("stallD", 32'(stallD), 32'(expStall));
    checkOutput("flushE", 32'(flushE), 32'(expStall));
    checkOutput("forwardAD", 32'(forwardAD), 32'(regwriteM && hit(rsD, writeregM)));
    checkOutput("forwardBD", 32'(forwardBD), 32'(regwriteM && hit(rtD, writeregM)));
    checkOutput("forwardAE", 32'(forwardAE), 32'(fwdE(rsE)));
    checkOutput("forwardBE", 32'(forwardBE), 32'(fwdE(rtE)));
    checkOutput("mcbusy", 32'(mcbusy), 32'(mcInFlight));
    checkOutput("mcdone", 32'(mcdone), 32'(expDone));
    checkOutput("mcdest", 32'(mcdest), 32'(mcDestRef));
    checkOutput("stallcnt", 32'(stallcnt), 32'(expCnt));

    @(posedge clk);
    if (reset) begin
      mcInFlight = 1'b0;
      mcDestRef  = '0;
      stallTotal = 0;
    end else begin
      if (expStall) stallTotal++;
      if (expDone) mcInFlight = 1'b0;
      else if (!mcInFlight && mcstartE) begin
        mcInFlight = 1'b1;
        mcStart    = cyc;
        mcDestRef  = writeregE;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    clearInputs();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    applyStimulus();

    rsE = 5; rtE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
    applyStimulus();
    regwriteM = 0;
    applyStimulus();
    rsE = 0;
    applyStimulus();
    clearInputs();

    memtoregE = 1; rtE = 7; rsD = 7;
    applyStimulus();
    rtE = 0; rsD = 0;
    applyStimulus();
    clearInputs();

    branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
    applyStimulus();
    regwriteE = 0; writeregE = 0; memtoregM = 1; writeregM = 3;
    applyStimulus();
    memtoregM = 0; regwriteM = 1;
    applyStimulus();
    clearInputs();

    mcstartE = 1; writeregE = 9; rsD = 9;
    applyStimulus();
    mcstartE = 0; writeregE = 0;
    repeat (5) applyStimulus();
    clearInputs();

    mcstartE = 1; writeregE = 10;
    applyStimulus();
    mcstartE = 0; writeregE = 0; mcD = 1;
    repeat (MC_LAT) applyStimulus();
    mcD = 0; mcstartE = 1; writeregE = 11;
    applyStimulus();
    clearInputs();
    repeat (MC_LAT + 1) applyStimulus();

    mcstartE = 1; writeregE = 12;
    applyStimulus();
    clearInputs();
    applyStimulus();
    reset = 1;
    applyStimulus();
    reset = 0;
    repeat (MC_LAT + 2) applyStimulus();

    memtoregE = 1; rtE = 7; rsD = 7;
    repeat (20) applyStimulus();
    checkOutput("stallcntSat", 32'(stallcnt), 32'(CNT_MAX));
    reset = 1;
    applyStimulus();
    clearInputs();
    applyStimulus();

    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      branchD   = 1'($urandom_range(0, 1));
      mcD       = ($urandom_range(0, 3) == 0);
      regwriteE = 1'($urandom_range(0, 1));
      regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = ($urandom_range(0, 3) == 0);
      memtoregM = ($urandom_range(0, 3) == 0);
      mcstartE  = ($urandom_range(0, 5) == 0);
      rsD = REG_AW'($urandom_range(0, 3)); rtD = REG_AW'($urandom_range(0, 3));
      rsE = REG_AW'($urandom_range(0, 3)); rtE = REG_AW'($urandom_range(0, 3));
      writeregE = REG_AW'($urandom_range(0, 3));
      writeregM = REG_AW'($urandom_range(0, 3));
      writeregW = REG_AW'($urandom_range(0, 3));
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
